// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer feeding a counter-qualified debounce FSM.
// Outputs b, rise, fall and busy are all registered.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic b,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, WAIT} state_t;

    state_t        state;
    state_t        state_nx;
    logic          sync1;
    logic          s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          b_nx;

    // A matching sample always wins over the count, so a bounce on the last
    // qualifying cycle still abandons the change.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        b_nx     = b;
        if (state == STABLE) begin
            if (s != b) begin
                state_nx = WAIT;
                cnt_nx   = CW'(1);
            end
        end else if (s == b) begin
            state_nx = STABLE;
        end else if (cnt == LAST) begin
            state_nx = STABLE;
            b_nx     = s;
        end else begin
            cnt_nx = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_LEVEL;
            s     <= RESET_LEVEL;
            state <= STABLE;
            cnt   <= '0;
            b     <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            sync1 <= a;
            s     <= sync1;
            state <= state_nx;
            cnt   <= cnt_nx;
            b     <= b_nx;
            rise  <= b_nx & ~b;
            fall  <= ~b_nx & b;
            busy  <= (state_nx == WAIT);
        end
    end
endmodule
